// File: rtl/exu_pkg.sv
// Shared constants for the execute-stage datapath core:
// datapath sizing, ALU operation codes and branch condition codes.
package exu_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_BLT  = 3'd3;
   localparam logic [2:0] BR_BGE  = 3'd4;
   localparam logic [2:0] BR_BLTU = 3'd5;
   localparam logic [2:0] BR_BGEU = 3'd6;
   localparam logic [2:0] BR_JUMP = 3'd7;

endpackage

// File: rtl/exu_regfile.sv
// 32-entry register file: synchronous reset/write, two asynchronous
// read ports, x0 hardwired to zero, no write-through bypass.
module exu_regfile
   import exu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            rf_wr_en,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (rf_wr_en && (waddr != '0)) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // x0 is forced on the read side as well, so it never depends on storage.
   assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/exu_datapath_core.sv
// Execute-stage datapath core: register file, combinational ALU and
// branch-condition comparator on the register read data.
module exu_datapath_core
   import exu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            rf_wr_en,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic [XLEN-1:0] alu_a,
   input  logic [XLEN-1:0] alu_b,
   input  logic [3:0]      alu_func,
   output logic [XLEN-1:0] alu_out,
   input  logic [2:0]      br_type,
   output logic            br_taken
);

   logic [4:0] shamt;
   logic       lt_s;
   logic       lt_u;
   logic       r_eq;
   logic       r_lt_s;
   logic       r_lt_u;

   exu_regfile u_rf (
      .clk      (clk),
      .rst      (rst),
      .rf_wr_en (rf_wr_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2)
   );

   assign shamt = alu_b[4:0];
   assign lt_s  = $signed(alu_a) < $signed(alu_b);
   assign lt_u  = alu_a < alu_b;

   always_comb begin
      alu_out = '0;
      case (alu_func)
         ALU_ADD:   alu_out = alu_a + alu_b;
         ALU_SUB:   alu_out = alu_a - alu_b;
         ALU_SLL:   alu_out = alu_a << shamt;
         ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, lt_u};
         ALU_XOR:   alu_out = alu_a ^ alu_b;
         ALU_SRL:   alu_out = alu_a >> shamt;
         ALU_SRA:   alu_out = $unsigned($signed(alu_a) >>> shamt);
         ALU_OR:    alu_out = alu_a | alu_b;
         ALU_AND:   alu_out = alu_a & alu_b;
         ALU_PASSB: alu_out = alu_b;
         default:   alu_out = '0;
      endcase
   end

   assign r_eq   = rdata1 == rdata2;
   assign r_lt_s = $signed(rdata1) < $signed(rdata2);
   assign r_lt_u = rdata1 < rdata2;

   always_comb begin
      br_taken = 1'b0;
      case (br_type)
         BR_NONE: br_taken = 1'b0;
         BR_BEQ:  br_taken = r_eq;
         BR_BNE:  br_taken = !r_eq;
         BR_BLT:  br_taken = r_lt_s;
         BR_BGE:  br_taken = !r_lt_s;
         BR_BLTU: br_taken = r_lt_u;
         BR_BGEU: br_taken = !r_lt_u;
         BR_JUMP: br_taken = 1'b1;
         default: br_taken = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_exu_datapath_core.sv
// Directed and randomized checks of exu_datapath_core against a
// behavioural register-file / ALU / branch model.
module tb_exu_datapath_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        rf_wr_en;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_func;
   logic [31:0] alu_out;
   logic [2:0]  br_type;
   logic        br_taken;

   int tests = 0;
   int fails = 0;
   logic [31:0] model [32];

   exu_datapath_core dut (
      .clk      (clk),
      .rst      (rst),
      .rf_wr_en (rf_wr_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_func (alu_func),
      .alu_out  (alu_out),
      .br_type  (br_type),
      .br_taken (br_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] alu_ref(input int f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int s;
      int sa;
      int sb;
      logic [31:0] ones;
      s    = int'(b % 32);
      sa   = a;
      sb   = b;
      ones = 32'hFFFF_FFFF;
      case (f)
         0:  return a + b;
         1:  return a - b;
         2:  return a << s;
         3:  return (sa < sb) ? 32'd1 : 32'd0;
         4:  return (a < b) ? 32'd1 : 32'd0;
         5:  return a ^ b;
         6:  return a >> s;
         7:  return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
         8:  return a | b;
         9:  return a & b;
         10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic br_ref(input int t,
                                   input logic [31:0] r1,
                                   input logic [31:0] r2);
      int s1;
      int s2;
      s1 = r1;
      s2 = r2;
      case (t)
         1: return r1 == r2;
         2: return r1 != r2;
         3: return s1 < s2;
         4: return s1 >= s2;
         5: return r1 < r2;
         6: return r1 >= r2;
         7: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      rf_wr_en = 1'b1;
      waddr    = a;
      wdata    = d;
      tick();
      rf_wr_en = 1'b0;
      if (a != 5'd0) model[a] = d;
   endtask

   task automatic alu_chk(input string tag, input logic [3:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      alu_func = f;
      alu_a    = a;
      alu_b    = b;
      #1;
      chk(tag, alu_out, exp);
   endtask

   initial begin
      logic [7:0]  exp_br;
      logic [31:0] ra;
      logic [31:0] rb;
      int          f;
      int          t;
      rst      = 1'b1;
      rf_wr_en = 1'b0;
      waddr    = '0;
      wdata    = '0;
      raddr1   = '0;
      raddr2   = '0;
      alu_a    = '0;
      alu_b    = '0;
      alu_func = '0;
      br_type  = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(31 - i);
         #1;
         chk($sformatf("rst_rd1_x%0d", i), rdata1, 32'd0);
         chk($sformatf("rst_rd2_x%0d", 31 - i), rdata2, 32'd0);
      end
      br_type = 3'd1;
      #1;
      chk("rst_beq", 32'(br_taken), 32'd1);

      raddr1   = 5'd5;
      raddr2   = 5'd0;
      rf_wr_en = 1'b1;
      waddr    = 5'd5;
      wdata    = 32'hDEAD_BEEF;
      #1;
      chk("no_bypass_x5", rdata1, 32'd0);
      wr(5'd5, 32'hDEAD_BEEF);
      wr(5'd0, 32'h1234_5678);
      chk("wr_x5", rdata1, 32'hDEAD_BEEF);
      chk("x0_zero", rdata2, 32'd0);
      raddr2 = 5'd5;
      #1;
      chk("same_reg_both", rdata2, 32'hDEAD_BEEF);

      alu_chk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_chk("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
      alu_chk("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_chk("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_chk("passb", 4'd10, 32'h1, 32'hABCD_0000, 32'hABCD_0000);
      alu_chk("sra", 4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
      alu_chk("srl", 4'd6, 32'h8000_0000, 32'h24, 32'h0800_0000);
      alu_chk("sll", 4'd2, 32'd1, 32'd31, 32'h8000_0000);
      alu_chk("and", 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
      alu_chk("or", 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
      alu_chk("xor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
      alu_chk("func15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

      wr(5'd1, 32'hFFFF_FFFF);
      wr(5'd2, 32'd1);
      raddr1 = 5'd1;
      raddr2 = 5'd2;
      exp_br = 8'b1100_1100;
      for (int i = 0; i < 8; i++) begin
         br_type = 3'(i);
         #1;
         chk($sformatf("br_m1_vs_1_t%0d", i), 32'(br_taken),
             32'(exp_br[i]));
      end
      raddr2  = 5'd1;
      br_type = 3'd1;
      #1;
      chk("br_x1_x1_beq", 32'(br_taken), 32'd1);

      wr(5'd3, 32'd5);
      rst      = 1'b1;
      rf_wr_en = 1'b1;
      waddr    = 5'd3;
      wdata    = 32'd7;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      raddr1 = 5'd3;
      #1;
      chk("rst_beats_wr", rdata1, 32'd0);
      tick();
      rf_wr_en = 1'b0;
      model[3] = 32'd7;
      chk("wr_after_rst", rdata1, 32'd7);

      for (int i = 0; i < 300; i++) begin
         f  = int'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 0) rb = {ra[31:16], 16'(rb)};
         alu_chk($sformatf("rnd_alu_f%0d", f), 4'(f), ra, rb,
                 alu_ref(f, ra, rb));
      end

      for (int i = 0; i < 300; i++) begin
         rf_wr_en = 1'($urandom_range(0, 1));
         waddr    = 5'($urandom_range(0, 31));
         wdata    = (i % 5 == 0) ? model[$urandom_range(0, 31)]
                                 : 32'($urandom);
         raddr1   = 5'($urandom_range(0, 31));
         raddr2   = (i % 6 == 0) ? raddr1 : 5'($urandom_range(0, 31));
         t        = int'($urandom_range(0, 7));
         br_type  = 3'(t);
         #1;
         chk("rnd_rd1", rdata1, model[raddr1]);
         chk("rnd_rd2", rdata2, model[raddr2]);
         chk($sformatf("rnd_br_t%0d", t), 32'(br_taken),
             32'(br_ref(t, model[raddr1], model[raddr2])));
         tick();
         if (rf_wr_en && waddr != 5'd0) model[waddr] = wdata;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
